apb_mem_slave: RTL and testbench

APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

---
 rtl/apb_mem_slave_if.sv | 25 ++
 rtl/apb_mem_slave.sv | 155 +++++++++++++++
 tb/tb_apb_mem_slave.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/apb_mem_slave_if.sv
// APB signal bundle between one master and the apb_mem_slave word memory.
interface apb_mem_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [3:0]            pstrb;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output paddr, pwrite, pwdata, pstrb, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwrite, pwdata, pstrb, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_mem_slave.sv
// APB slave backed by a DEPTH-word register memory with fixed wait states,
// byte strobes, error response on bad addresses and a saturating error counter.
module apb_mem_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    apb_mem_slave_if.slave      bus,
    output logic [7:0]          err_count
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;

    logic [IDX_W-1:0]      lat_idx;
    logic                  lat_err;
    logic                  lat_write;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [3:0]            lat_strb;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  pready_r, pready_n;
    logic                  pslverr_r, pslverr_n;
    logic [DATA_WIDTH-1:0] prdata_r, prdata_n;

    logic                  access;
    logic                  start;
    logic [ADDR_WIDTH-3:0] word_addr;
    logic                  dec_err;
    logic [IDX_W-1:0]      dec_idx;
    logic                  eff_err;
    logic                  eff_write;
    logic [IDX_W-1:0]      eff_idx;
    logic                  commit;
    logic                  err_inc;

    always_comb begin
        access    = bus.psel & bus.penable;
        start     = (state == IDLE) & access;
        word_addr = bus.paddr[ADDR_WIDTH-1:2];
        dec_err   = (word_addr >= (ADDR_WIDTH-2)'(DEPTH)) | (bus.paddr[1:0] != 2'b00);
        dec_idx   = bus.paddr[IDX_W+1:2];
        // With zero wait states DONE follows IDLE directly, so use the live decode.
        eff_err   = start ? dec_err     : lat_err;
        eff_write = start ? bus.pwrite  : lat_write;
        eff_idx   = start ? dec_idx     : lat_idx;
        commit    = (state == DONE) & access & ~lat_err & lat_write;
        err_inc   = (state == DONE) & access & lat_err & (err_count != 8'hFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // cnt counts the WAIT cycles still to spend, including the current one.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (access) begin
                    cnt_n   = CNT_W'(WAIT_CYCLES);
                    state_n = (WAIT_CYCLES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (!access) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt <= CNT_W'(1)) begin
                    state_n = DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        pready_n  = (state_n == DONE);
        pslverr_n = (state_n == DONE) & eff_err;
        prdata_n  = prdata_r;
        if ((state_n == DONE) && !eff_write) begin
            prdata_n = eff_err ? '0 : mem[eff_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            prdata_r  <= '0;
            err_count <= '0;
            lat_idx   <= '0;
            lat_err   <= 1'b0;
            lat_write <= 1'b0;
            lat_wdata <= '0;
            lat_strb  <= '0;
        end else begin
            pready_r  <= pready_n;
            pslverr_r <= pslverr_n;
            prdata_r  <= prdata_n;
            if (err_inc) begin
                err_count <= err_count + 8'd1;
            end
            if (start) begin
                lat_idx   <= dec_idx;
                lat_err   <= dec_err;
                lat_write <= bus.pwrite;
                lat_wdata <= bus.pwdata;
                lat_strb  <= bus.pstrb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else if (commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lat_strb[i]) begin
                    mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.pready  = pready_r;
    assign bus.pslverr = pslverr_r;
    assign bus.prdata  = prdata_r;
endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: transfer-level memory model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_apb_mem_slave;
    localparam int W     = 2;
    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] err_count;

    apb_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_mem_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .WAIT_CYCLES(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transfer-level model
    logic [31:0] model_mem [DEPTH];
    logic [7:0]  model_err_count = 8'd0;
    logic [31:0] model_prdata    = 32'd0;
    int          done_cyc        = -1;
    bit          cur_err;
    bit          cur_write;
    int          cur_idx;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_strb;
    bit          checking        = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit exp_ready;
        if (checking) begin
            exp_ready = (cyc == done_cyc);
            if (exp_ready && !cur_write)
                model_prdata = cur_err ? 32'd0 : model_mem[cur_idx];
            check("pready",    {31'd0, bus.pready},  {31'd0, exp_ready});
            check("pslverr",   {31'd0, bus.pslverr}, {31'd0, exp_ready && cur_err});
            check("prdata",    bus.prdata,           model_prdata);
            check("err_count", {24'd0, err_count},   {24'd0, model_err_count});
            if (exp_ready) begin
                if (cur_err) begin
                    if (model_err_count != 8'hFF) model_err_count = model_err_count + 8'd1;
                end else if (cur_write) begin
                    for (int b = 0; b < 4; b++)
                        if (cur_strb[b]) model_mem[cur_idx][8*b +: 8] = cur_wdata[8*b +: 8];
                end
            end
        end
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) model_mem[k] = 32'd0;
            model_err_count = 8'd0;
            model_prdata    = 32'd0;
            done_cyc        = -1;
        end
    end

    // mode: 0 normal, 1 change inputs during WAIT, 2 abort after start, 3 reset during WAIT
    task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                        input logic [3:0] st, input int mode);
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0;
        bus.paddr = addr; bus.pwrite = wr; bus.pwdata = wd; bus.pstrb = st;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        cur_err   = (addr >= 32'(4 * DEPTH)) || (addr[1:0] != 2'b00);
        cur_write = wr;
        cur_idx   = int'(addr[7:2]);
        cur_wdata = wd;
        cur_strb  = st;
        done_cyc  = cyc + 1 + W;
        @(posedge clk); #1;
        if (mode == 2) begin
            done_cyc = -1;
            bus.psel = 1'b0; bus.penable = 1'b0;
            return;
        end
        if (mode == 3) begin
            done_cyc = -1;
            rst = 1'b1;
            bus.psel = 1'b0; bus.penable = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            check("rst_mid_pready",  {31'd0, bus.pready},  32'd0);
            check("rst_mid_pslverr", {31'd0, bus.pslverr}, 32'd0);
            check("rst_mid_prdata",  bus.prdata,           32'd0);
            check("rst_mid_errcnt",  {24'd0, err_count},   32'd0);
            return;
        end
        if (mode == 1) begin
            bus.paddr = 32'h0000_0044; bus.pwrite = ~wr;
            bus.pwdata = 32'h0BAD_0BAD; bus.pstrb = 4'h3;
        end
        while (cyc < done_cyc) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    initial begin
        bus.psel = 1'b0; bus.penable = 1'b0; bus.paddr = '0;
        bus.pwrite = 1'b0; bus.pwdata = '0; bus.pstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checking = 1'b1;
        check("reset_pready",  {31'd0, bus.pready},  32'd0);
        check("reset_prdata",  bus.prdata,           32'd0);
        check("reset_errcnt",  {24'd0, err_count},   32'd0);

        xfer(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0);
        xfer(32'h10, 1'b0, 32'h0,        4'h0, 0);
        check("rd_0x10", bus.prdata, 32'hDEADBEEF);

        xfer(32'h04, 1'b1, 32'h11223344, 4'hF, 0);
        xfer(32'h04, 1'b1, 32'hAABBCCDD, 4'b0101, 0);
        xfer(32'h04, 1'b0, 32'h0,        4'h0, 0);
        check("strobe_merge", bus.prdata, 32'h11BB33DD);

        xfer(32'h10, 1'b1, 32'h01234567, 4'h0, 0);
        xfer(32'h10, 1'b0, 32'h0,        4'h0, 0);
        check("strb0_noop", bus.prdata, 32'hDEADBEEF);

        xfer(32'h100, 1'b0, 32'h0,        4'h0, 0);
        check("err_rd_zero", bus.prdata, 32'h0);
        xfer(32'h02,  1'b1, 32'hFFFFFFFF, 4'hF, 0);
        check("err_count2", {24'd0, err_count}, 32'd2);
        xfer(32'h00,  1'b0, 32'h0,        4'h0, 0);
        check("err_wr_nochg", bus.prdata, 32'h0);

        xfer(32'h20, 1'b1, 32'hCAFEF00D, 4'hF, 1);
        xfer(32'h44, 1'b0, 32'h0,        4'h0, 0);
        check("latch_other", bus.prdata, 32'h0);
        xfer(32'h20, 1'b0, 32'h0,        4'h0, 1);
        check("latch_rd", bus.prdata, 32'hCAFEF00D);

        xfer(32'h10, 1'b1, 32'h12345678, 4'hF, 2);
        xfer(32'h10, 1'b0, 32'h0,        4'h0, 0);
        check("abort_nochg", bus.prdata, 32'hDEADBEEF);

        xfer(32'h08, 1'b1, 32'h55AA55AA, 4'hF, 0);
        xfer(32'h08, 1'b1, 32'h77777777, 4'hF, 3);
        xfer(32'h08, 1'b0, 32'h0,        4'h0, 0);
        check("rst_rd_0x08", bus.prdata, 32'h0);
        xfer(32'h10, 1'b0, 32'h0,        4'h0, 0);
        check("rst_rd_0x10", bus.prdata, 32'h0);

        for (int i = 0; i < 260; i++) begin
            xfer(32'h104, 1'b0, 32'h0, 4'h0, 0);
            if (i >= 254) check("err_sat", {24'd0, err_count}, 32'd255);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
